banana_drop_controller: RTL and testbench
=========================================

# banana_drop_controller

Position and lifetime controller for the enemy banana projectile, directly upstream of the banana bitmap stage. On a fire request it latches the launching alien's position. It then moves the banana down by a fixed step once per frame. It drives the top-left coordinate consumed by the rectangle/offset stage, and the `appear` qualifier consumed by the bitmap's drawing request. It retires the banana on player collision or at the bottom of the screen, then enforces a cooldown before the next shot.

## Interface
Parameters:
- SPEED_Y, 4: pixels added to Y per frame while falling.
- COOLDOWN_FRAMES, 30: frames spent in COOLDOWN after retirement.
- OBJECT_WIDTH, 32: banana width in pixels.
- OBJECT_HEIGHT, 32: banana height in pixels.
- SCREEN_WIDTH, 640: visible width.
- SCREEN_HEIGHT, 480: visible height.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low; one clock domain only.
- startOfFrame  in  1  one-cycle pulse per frame.
- fireRequest  in  1  one-cycle pulse from the alien fleet requesting a shot.
- launchX  in  11  top-left X of the banana at launch.
- launchY  in  11  top-left Y of the banana at launch.
- collision  in  1  banana/player overlap from the collision detector (level, sampled each cycle).
- topLeftX  out  11  banana top-left X.
- topLeftY  out  11  banana top-left Y.
- appear  out  1  banana visible/alive; feeds the bitmap `appear` input.
- hitPlayer  out  1  one-cycle pulse when retired by collision.
- missed  out  1  one-cycle pulse when retired at the screen bottom.

## Operation
- Derived limits:
  - Y_LIMIT = SCREEN_HEIGHT − OBJECT_HEIGHT (448).
  - X_LIMIT = SCREEN_WIDTH − OBJECT_WIDTH (608).
- States: IDLE, FALLING, COOLDOWN. All outputs are registered.
- IDLE (appear=0):
  - fireRequest with launchY ≤ Y_LIMIT → latch topLeftX = min(launchX, X_LIMIT) and topLeftY = launchY, then go to FALLING.
  - fireRequest with launchY > Y_LIMIT is dropped; the block stays in IDLE.
- FALLING (appear=1):
  - collision=1 → go to COOLDOWN and pulse hitPlayer. This has priority over startOfFrame in the same cycle, and Y does not advance.
  - Otherwise on startOfFrame:
    - if topLeftY + SPEED_Y > Y_LIMIT → go to COOLDOWN and pulse missed; Y is left unchanged.
    - else topLeftY += SPEED_Y.
  - topLeftX is constant while FALLING.
- COOLDOWN (appear=0):
  - The frame counter is loaded with COOLDOWN_FRAMES on entry.
  - Each startOfFrame decrements the counter. A startOfFrame that finds the counter at 0 moves the block to IDLE.
  - COOLDOWN_FRAMES=0 → the first startOfFrame returns the block to IDLE.
- fireRequest outside IDLE is ignored; it is not queued.
- topLeftX/topLeftY hold their last value in COOLDOWN and IDLE; the downstream stage gates drawing with appear.
- Arithmetic: the Y sum is computed in 12 bits unsigned, so it never wraps. The counter is sized as $clog2(COOLDOWN_FRAMES+1), minimum 1 bit.

## Timing
- Reset values: state=IDLE, topLeftX=0, topLeftY=0, appear=0, hitPlayer=0, missed=0, counter=0.
- fireRequest at cycle N → appear=1 and the latched coordinates are valid at N+1.
- startOfFrame at cycle N → the new topLeftY is visible at N+1.
- collision at N → appear=0 and hitPlayer=1 at N+1. hitPlayer is exactly one cycle wide.
- Bottom retirement at startOfFrame N → appear=0 and missed=1 at N+1.
- The bitmap stage registers its pixel output, so the visible disappearance lags appear by its one-cycle pipeline. This is acceptable.
- Reset asserted mid-flight forces IDLE immediately (asynchronously). No pulse is emitted and no cooldown applies after release.
- fireRequest arriving in the same cycle as the COOLDOWN→IDLE transition is ignored; the block must be in IDLE on the cycle fireRequest is sampled.

## Test plan
- Reset then fire: fireRequest with launchX=100, launchY=50 → next cycle appear=1, topLeftX=100, topLeftY=50. Three startOfFrame pulses → topLeftY=62.
- Bottom miss: launchY=440, startOfFrame → topLeftY=444. Next startOfFrame (444+4=448 ≤ 448) → 448. Next startOfFrame → missed one-cycle pulse, appear=0, topLeftY stays 448.
- Collision priority: while FALLING at Y=200, assert collision and startOfFrame in the same cycle → hitPlayer pulse, topLeftY=200, appear=0.
- Cooldown: COOLDOWN_FRAMES=2. After retirement, a fireRequest before the 3rd startOfFrame is ignored. After the 3rd, the state is IDLE and a fireRequest relaunches.
- Clamp and reject:
  - launchX=630 → topLeftX=608.
  - launchY=460 → fire dropped, appear stays 0.
- Reset mid-flight: resetN low while FALLING → all outputs 0 asynchronously. After release, an immediate fireRequest is accepted.

Source files
------------

// File: rtl/banana_drop_controller.sv
// -----------------------------------------------------------------------------
// banana_drop_controller
// Position and lifetime controller for the enemy banana projectile. Latches the
// launching alien's position on a fire request, drops the banana by SPEED_Y
// pixels each frame, retires it on player collision or at the screen bottom,
// then holds off further shots for COOLDOWN_FRAMES frames.
//
// Ports:
//   clk, resetN           clock, asynchronous active-low reset
//   startOfFrame          one-cycle pulse per frame
//   fireRequest           one-cycle shot request from the alien fleet
//   launchX, launchY      top-left launch coordinate (11 bits each)
//   collision             banana/player overlap level
//   topLeftX, topLeftY    banana top-left coordinate (registered)
//   appear                banana alive/visible (registered)
//   hitPlayer             one-cycle pulse on collision retirement (registered)
//   missed                one-cycle pulse on bottom retirement (registered)
// -----------------------------------------------------------------------------
module banana_drop_controller #(
  parameter int unsigned SPEED_Y         = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned OBJECT_WIDTH    = 32,
  parameter int unsigned OBJECT_HEIGHT   = 32,
  parameter int unsigned SCREEN_WIDTH    = 640,
  parameter int unsigned SCREEN_HEIGHT   = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fireRequest,
  input  logic [10:0] launchX,
  input  logic [10:0] launchY,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        appear,
  output logic        hitPlayer,
  output logic        missed
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned Y_LIMIT = SCREEN_HEIGHT - OBJECT_HEIGHT;
  localparam int unsigned X_LIMIT = SCREEN_WIDTH - OBJECT_WIDTH;
  localparam int unsigned CNT_RAW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FALLING  = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 appear_q, appear_d;
  logic                 hit_q, hit_d;
  logic                 missed_q, missed_d;
  logic [SUM_W-1:0]     y_sum;

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      appear_q <= 1'b0;
      hit_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      appear_q <= appear_d;
      hit_q    <= hit_d;
      missed_q <= missed_d;
    end
  end

  // Next-state, coordinate and pulse logic
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    missed_d = 1'b0;
    // One extra bit so the bottom test cannot wrap
    y_sum    = SUM_W'(y_q) + SUM_W'(SPEED_Y);

    case (state_q)
      ST_IDLE: begin
        if (fireRequest && (launchY <= COORD_W'(Y_LIMIT))) begin
          state_d = ST_FALLING;
          x_d     = (launchX > COORD_W'(X_LIMIT)) ? COORD_W'(X_LIMIT) : launchX;
          y_d     = launchY;
        end
      end

      ST_FALLING: begin
        // Collision wins over a coincident frame tick; Y is frozen
        if (collision) begin
          state_d = ST_COOLDOWN;
          cnt_d   = CNT_W'(COOLDOWN_FRAMES);
          hit_d   = 1'b1;
        end else if (startOfFrame) begin
          if (y_sum > SUM_W'(Y_LIMIT)) begin
            state_d  = ST_COOLDOWN;
            cnt_d    = CNT_W'(COOLDOWN_FRAMES);
            missed_d = 1'b1;
          end else begin
            y_d = COORD_W'(y_sum);
          end
        end
      end

      ST_COOLDOWN: begin
        // A frame tick that finds the counter empty ends the cooldown
        if (startOfFrame) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    appear_d = (state_d == ST_FALLING);
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign appear    = appear_q;
  assign hitPlayer = hit_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_banana_drop_controller.sv
// -----------------------------------------------------------------------------
// tb_banana_drop_controller
// Self-checking bench: directed scenarios followed by random stimulus, all
// compared cycle by cycle against a behavioural model of the projectile.
// -----------------------------------------------------------------------------
module tb_banana_drop_controller;

  localparam int SPEED   = 4;
  localparam int CD      = 2;
  localparam int YLIM    = 480 - 32;
  localparam int XLIM    = 640 - 32;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        fireRequest;
  logic [10:0] launchX;
  logic [10:0] launchY;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        appear;
  logic        hitPlayer;
  logic        missed;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_alive;
  bit m_cooling;
  int m_cd_ticks;
  int m_x, m_y;
  bit m_hit, m_miss;

  banana_drop_controller #(
    .SPEED_Y(SPEED), .COOLDOWN_FRAMES(CD), .OBJECT_WIDTH(32), .OBJECT_HEIGHT(32),
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireRequest(fireRequest),
    .launchX(launchX), .launchY(launchY), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .appear(appear),
    .hitPlayer(hitPlayer), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_alive = 0; m_cooling = 0; m_cd_ticks = 0;
    m_x = 0; m_y = 0; m_hit = 0; m_miss = 0;
  endfunction

  // Behavioural rules: the cooldown lasts until CD+1 frame ticks have been seen
  function automatic void model_step(bit sof, bit fire, int lx, int ly, bit col);
    m_hit = 0; m_miss = 0;
    if (m_alive) begin
      if (col) begin
        m_alive = 0; m_hit = 1; m_cooling = 1; m_cd_ticks = 0;
      end else if (sof) begin
        if (m_y + SPEED > YLIM) begin
          m_alive = 0; m_miss = 1; m_cooling = 1; m_cd_ticks = 0;
        end else begin
          m_y = m_y + SPEED;
        end
      end
    end else if (m_cooling) begin
      if (sof) begin
        m_cd_ticks++;
        if (m_cd_ticks > CD) m_cooling = 0;
      end
    end else if (fire && ly <= YLIM) begin
      m_alive = 1;
      m_x = (lx > XLIM) ? XLIM : lx;
      m_y = ly;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".x"},      32'(topLeftX),  32'(m_x));
    check({tag, ".y"},      32'(topLeftY),  32'(m_y));
    check({tag, ".appear"}, 32'(appear),    32'(m_alive));
    check({tag, ".hit"},    32'(hitPlayer), 32'(m_hit));
    check({tag, ".missed"}, 32'(missed),    32'(m_miss));
  endtask

  // One clock: drive inputs, advance model and DUT, compare after the edge
  task automatic cycle(input string tag, input bit sof, input bit fire,
                       input int lx, input int ly, input bit col);
    startOfFrame = sof;
    fireRequest  = fire;
    launchX      = 11'(lx);
    launchY      = 11'(ly);
    collision    = col;
    @(posedge clk);
    model_step(sof, fire, lx, ly, col);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_cycle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 0; fireRequest = 0;
    launchX = '0; launchY = '0; collision = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    resetN = 1'b1;
    idle_cycle("post_reset");

    // Fire and fall three frames
    cycle("fire", 0, 1, 100, 50, 0);
    check("fire_x", 32'(topLeftX), 100);
    check("fire_y", 32'(topLeftY), 50);
    check("fire_appear", 32'(appear), 1);
    for (int i = 0; i < 3; i++) begin
      cycle("fall", 1, 0, 0, 0, 0);
      idle_cycle("fall_gap");
    end
    check("fall_y62", 32'(topLeftY), 62);

    // Collision coincident with frame tick
    cycle("col_sof", 1, 0, 0, 0, 1);
    check("col_hit", 32'(hitPlayer), 1);
    check("col_y", 32'(topLeftY), 62);
    check("col_appear", 32'(appear), 0);
    idle_cycle("col_after");
    check("hit_width", 32'(hitPlayer), 0);

    // Cooldown: fire before third tick is ignored
    cycle("cd_sof1", 1, 0, 0, 0, 0);
    cycle("cd_sof2", 1, 0, 0, 0, 0);
    cycle("cd_fire_early", 0, 1, 30, 30, 0);
    check("cd_ignored", 32'(appear), 0);
    cycle("cd_sof3_fire", 1, 1, 30, 30, 0);
    check("cd_same_cycle_ignored", 32'(appear), 0);

    // Relaunch with X clamp, then bottom miss
    cycle("clamp_fire", 0, 1, 630, 440, 0);
    check("clamp_x", 32'(topLeftX), 608);
    cycle("bot1", 1, 0, 0, 0, 0);
    check("bot_444", 32'(topLeftY), 444);
    cycle("bot2", 1, 0, 0, 0, 0);
    check("bot_448", 32'(topLeftY), 448);
    cycle("bot3", 1, 0, 0, 0, 0);
    check("bot_missed", 32'(missed), 1);
    check("bot_appear", 32'(appear), 0);
    check("bot_y_held", 32'(topLeftY), 448);
    idle_cycle("bot_after");
    check("missed_width", 32'(missed), 0);

    // Drain cooldown, reject low launch, collision at 200
    for (int i = 0; i < 3; i++) cycle("drain", 1, 0, 0, 0, 0);
    cycle("reject", 0, 1, 10, 460, 0);
    check("reject_appear", 32'(appear), 0);
    cycle("fire200", 0, 1, 10, 200, 0);
    cycle("col200", 1, 0, 0, 0, 1);
    check("col200_y", 32'(topLeftY), 200);
    check("col200_hit", 32'(hitPlayer), 1);

    // Asynchronous reset mid-flight
    for (int i = 0; i < 3; i++) cycle("drain2", 1, 0, 0, 0, 0);
    cycle("fire_rst", 0, 1, 20, 100, 0);
    cycle("fall_rst", 1, 0, 0, 0, 0);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("async_appear", 32'(appear), 0);
    check("async_x", 32'(topLeftX), 0);
    check("async_y", 32'(topLeftY), 0);
    #2 resetN = 1'b1;
    cycle("fire_after_rst", 0, 1, 77, 33, 0);
    check("rst_refire", 32'(appear), 1);
    check("rst_refire_y", 32'(topLeftY), 33);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit sof, fire, col;
      int lx, ly;
      sof  = ($urandom_range(3) == 0);
      fire = ($urandom_range(5) == 0);
      col  = ($urandom_range(24) == 0);
      lx   = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) : int'($urandom_range(700));
      ly   = ($urandom_range(7) == 0) ? int'($urandom_range(2047)) : int'($urandom_range(480));
      if ($urandom_range(499) == 0) begin
        @(negedge clk);
        resetN = 1'b0;
        #1;
        model_reset();
        compare_all("rand_rst");
        #1 resetN = 1'b1;
      end
      cycle("rand", sof, fire, lx, ly, col);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
